// File: rtl/spike_event_scheduler.sv
// spike_event_scheduler: timestamped (time, row) event FIFO with a local timebase.
// Each event is dispatched as a one-cycle pulse on its synapse row when the
// timebase reaches the event time.
// Optional build macro SPIKE_SCHED_LATE_CNT_EN adds a saturating late_count
// output that counts dropped (late or invalid-row) events.
`timescale 1ns/100ps
module spike_event_scheduler #(
    parameter int unsigned  NUM_SYNAPSE_ROWS = 2,
    parameter int unsigned  TIME_WIDTH       = 16,
    parameter int unsigned  FIFO_DEPTH       = 8,
    localparam int unsigned ROW_WIDTH        = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
    localparam int unsigned LVL_WIDTH        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        run,
    input  logic                        clear,
    input  logic                        evt_valid,
    output logic                        evt_ready,
    input  logic [TIME_WIDTH-1:0]       evt_time,
    input  logic [ROW_WIDTH-1:0]        evt_row,
    output logic [NUM_SYNAPSE_ROWS-1:0] spike_out,
    output logic [TIME_WIDTH-1:0]       systime,
    output logic [LVL_WIDTH-1:0]        fifo_level,
`ifdef SPIKE_SCHED_LATE_CNT_EN
    output logic [15:0]                 late_count,
`endif
    output logic                        busy
);

    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [TIME_WIDTH-1:0] ts;
        logic [ROW_WIDTH-1:0]  row;
    } evt_t;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                      state_q, state_d;
    logic [TIME_WIDTH-1:0]       systime_q, systime_d;
    logic [PTR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_WIDTH-1:0]        level_q, level_d;
    logic [NUM_SYNAPSE_ROWS-1:0] spike_q, spike_d;
    logic                        busy_q, busy_d;
    evt_t                        mem_q [FIFO_DEPTH];

    evt_t                        head;
    logic [TIME_WIDTH-1:0]       delta;
    logic                        full, empty, active, push, pop;
    logic                        head_due, head_late, row_ok;

    // Queue status and dispatch decode for the head entry
    assign full      = (level_q == LVL_WIDTH'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    assign evt_ready = !full;
    assign head      = mem_q[rd_ptr_q];
    assign delta     = head.ts - systime_q;
    assign head_due  = (delta == '0);
    assign head_late = delta[TIME_WIDTH-1];
    assign row_ok    = (32'(head.row) < NUM_SYNAPSE_ROWS);
    // Qualifying with run keeps a pulse from landing in a cycle that is already IDLE
    assign active    = (state_q == RUN) && run && !clear;
    assign push      = evt_valid && !full && !clear;
    assign pop       = active && !empty && (head_due || head_late);

    // Next-state: FSM, timebase, FIFO pointers/level and spike pulse
    always_comb begin
        state_d   = state_q;
        systime_d = systime_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        spike_d   = '0;
        if (clear) begin
            state_d   = IDLE;
            systime_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
        end else begin
            state_d = run ? RUN : IDLE;
            if (active) begin
                systime_d = systime_q + TIME_WIDTH'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_WIDTH'(1);
                2'b01:   level_d = level_q - LVL_WIDTH'(1);
                default: level_d = level_q;
            endcase
            if (pop && head_due && row_ok) begin
                for (int unsigned i = 0; i < NUM_SYNAPSE_ROWS; i++) begin
                    spike_d[i] = (32'(head.row) == i);
                end
            end
        end
        busy_d = (level_d != '0);
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            systime_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            spike_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            systime_q <= systime_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            spike_q   <= spike_d;
            busy_q    <= busy_d;
        end
    end

    // Event storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= evt_t'{ts: evt_time, row: evt_row};
        end
    end

    assign spike_out  = spike_q;
    assign systime    = systime_q;
    assign fifo_level = level_q;
    assign busy       = busy_q;

`ifdef SPIKE_SCHED_LATE_CNT_EN
    logic [15:0] late_cnt_q, late_cnt_d;
    logic        drop;

    // Any pop that does not produce a pulse is a drop
    assign drop = pop && !(head_due && row_ok);

    // Saturating drop counter next-state
    always_comb begin
        late_cnt_d = late_cnt_q;
        if (clear) begin
            late_cnt_d = '0;
        end else if (drop && (late_cnt_q != 16'hFFFF)) begin
            late_cnt_d = late_cnt_q + 16'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            late_cnt_q <= '0;
        end else begin
            late_cnt_q <= late_cnt_d;
        end
    end

    assign late_count = late_cnt_q;
`endif

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Bench for spike_event_scheduler: directed stimulus, expected pulses queued
// as events are pushed and checked by an independent output monitor.
`timescale 1ns/100ps
module tb_spike_event_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic [15:0] evt_time = '0;
    logic [0:0]  evt_row = '0;
    logic [1:0]  spike_out;
    logic [15:0] systime;
    logic [3:0]  fifo_level;
    logic        busy;
`ifdef SPIKE_SCHED_LATE_CNT_EN
    logic [15:0] late_count;
`endif

    always #5 clk = ~clk;

    spike_event_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .clear      (clear),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_time   (evt_time),
        .evt_row    (evt_row),
        .spike_out  (spike_out),
        .systime    (systime),
        .fifo_level (fifo_level),
`ifdef SPIKE_SCHED_LATE_CNT_EN
        .late_count (late_count),
`endif
        .busy       (busy)
    );

    typedef struct {
        logic [15:0] ts;
        logic [1:0]  spk;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_spike(input logic [15:0] ts, input logic [1:0] spk);
        exp_t e;
        e.ts  = ts;
        e.spk = spk;
        sb_q.push_back(e);
    endtask

    // Monitor: every visible pulse must match the oldest expected pulse
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (spike_out != 2'b00)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_spike: got spike=%b at systime=%0d expected none", spike_out, systime);
            end else begin
                e = sb_q.pop_front();
                chk("spike_row", 32'(spike_out), 32'(e.spk));
                chk("spike_time", 32'(systime), 32'(e.ts));
            end
        end
    end

    task automatic push_evt(input logic [15:0] t, input logic [0:0] r);
        evt_valid = 1'b1;
        evt_time  = t;
        evt_row   = r;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; (i < bound) && (sb_q.size() != 0); i++) @(negedge clk);
        chk("drain", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_sys(input logic [15:0] target, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((systime != target) && (n < bound));
        chk("wait_sys", 32'(systime), 32'(target));
    endtask

    initial begin
        int n;

        // Reset values while reset_n is held low
        #12;
        chk("rst_spike", 32'(spike_out), 32'd0);
        chk("rst_systime", 32'(systime), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(evt_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Single event (5,1): pulse on row 1 visible when systime reads 6
        @(posedge clk);
        #1;
        run = 1'b1;
        expect_spike(16'd6, 2'b10);
        push_evt(16'd5, 1'b1);
        @(negedge clk);
        chk("t1_level", 32'(fifo_level), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        drain(50);
        chk("t1_level_end", 32'(fifo_level), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Same-time pair: (3,1) is late behind (3,0) and dropped
        run = 1'b0;
        do_clear();
        @(negedge clk);
        chk("clear_systime", 32'(systime), 32'd0);
        @(posedge clk);
        #1;
        expect_spike(16'd4, 2'b01);
        expect_spike(16'd8, 2'b01);
        push_evt(16'd3, 1'b0);
        push_evt(16'd3, 1'b1);
        push_evt(16'd7, 1'b0);
        run = 1'b1;
        drain(40);
        chk("t2_level_end", 32'(fifo_level), 32'd0);
`ifdef SPIKE_SCHED_LATE_CNT_EN
        chk("t2_late_count", 32'(late_count), 32'd1);
`endif

        // Full FIFO: 9th push stalls until the first pop frees a slot
        run = 1'b0;
        do_clear();
        for (int i = 0; i < 8; i++) push_evt(16'd100, 1'b0);
        @(negedge clk);
        chk("t3_ready_full", 32'(evt_ready), 32'd0);
        chk("t3_level_full", 32'(fifo_level), 32'd8);
        evt_valid = 1'b1;
        evt_time  = 16'd200;
        evt_row   = 1'b1;
        expect_spike(16'd101, 2'b01);
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!evt_ready && (n < 300));
        chk("t3_ready_release", 32'(evt_ready), 32'd1);
        chk("t3_level_release", 32'(fifo_level), 32'd7);
        chk("t3_systime_release", 32'(systime), 32'd101);
        expect_spike(16'd201, 2'b10);
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
        @(negedge clk);
        chk("t3_push_pop_level", 32'(fifo_level), 32'd7);
        drain(200);
        chk("t3_level_end", 32'(fifo_level), 32'd0);
`ifdef SPIKE_SCHED_LATE_CNT_EN
        chk("t3_late_count", 32'(late_count), 32'd7);
`endif

        // Pause at systime 10, then resume; event at 12 pulses at 13
        run = 1'b0;
        do_clear();
        run = 1'b1;
        wait_sys(16'd10, 50);
        run = 1'b0;
        expect_spike(16'd13, 2'b01);
        push_evt(16'd12, 1'b0);
        repeat (20) @(negedge clk);
        chk("t4_hold_systime", 32'(systime), 32'd10);
        chk("t4_hold_level", 32'(fifo_level), 32'd1);
        run = 1'b1;
        drain(20);

        // Timebase wrap: (2,1) pushed at 65530 is future, pulses at 3
        run = 1'b0;
        do_clear();
        run = 1'b1;
        wait_sys(16'd65530, 70000);
        expect_spike(16'd3, 2'b10);
        push_evt(16'd2, 1'b1);
        drain(30);

        // Clear mid-run with 4 queued events
        push_evt(16'd1000, 1'b0);
        push_evt(16'd1001, 1'b1);
        push_evt(16'd1002, 1'b0);
        push_evt(16'd1003, 1'b1);
        @(negedge clk);
        chk("t6_level_queued", 32'(fifo_level), 32'd4);
        do_clear();
        @(negedge clk);
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_systime", 32'(systime), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(evt_ready), 32'd1);
        chk("t6_spike", 32'(spike_out), 32'd0);
`ifdef SPIKE_SCHED_LATE_CNT_EN
        chk("t6_late_count", 32'(late_count), 32'd0);
`endif
        @(negedge clk);
        chk("t6_idle_systime", 32'(systime), 32'd0);

        // Async reset pulse mid-cycle cancels a visible spike immediately
        wait_sys(16'd5, 20);
        expect_spike(16'd10, 2'b10);
        push_evt(16'd9, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((spike_out == 2'b00) && (n < 20));
        chk("t7_spike_seen", 32'(spike_out), 32'd2);
        #1;
        reset_n = 1'b0;
        #0.5;
        chk("t7_rst_spike", 32'(spike_out), 32'd0);
        chk("t7_rst_systime", 32'(systime), 32'd0);
        chk("t7_rst_level", 32'(fifo_level), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_ready", 32'(evt_ready), 32'd1);
        #0.5;
        reset_n = 1'b1;
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
